// File: rtl/fault_mem_multi.sv
// Single-port word memory with a configurable injected fault model.
// Every cycle carries one operation: a write or a read. It goes through
// the S1 stage and then commits or reads the array.
module fault_mem_multi #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned CAPACITY   = 64,
   localparam int unsigned BIT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  write_read,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   input  logic                  cfg_load,
   input  logic [2:0]            cfg_mode,
   input  logic [ADDR_WIDTH-1:0] cfg_victim,
   input  logic [ADDR_WIDTH-1:0] cfg_aggr,
   input  logic [BIT_W-1:0]      cfg_bit,
   output logic [15:0]           fault_hits
);

   typedef enum logic [2:0] {
      M_NONE = 3'd0, M_SA0 = 3'd1, M_SA1 = 3'd2, M_TUP = 3'd3,
      M_TDN  = 3'd4, M_CPL = 3'd5, M_NPSF = 3'd6, M_RSVD = 3'd7
   } mode_t;

   logic                  s1_wr;
   logic [ADDR_WIDTH-1:0] s1_addr;
   logic [DATA_WIDTH-1:0] s1_wdata;
   logic [DATA_WIDTH-1:0] rd_q;

   mode_t                 mode_q;
   logic [ADDR_WIDTH-1:0] vic_q;
   logic [ADDR_WIDTH-1:0] aggr_q;
   logic [BIT_W-1:0]      bit_q;

   // mem holds the faulty contents; ideal holds what a fault-free array would hold
   logic [DATA_WIDTH-1:0] mem   [CAPACITY];
   logic [DATA_WIDTH-1:0] ideal [CAPACITY];

   logic                  addr_ok, vic_ok, at_vic;
   logic                  we, cpl_flip, hit;
   logic                  old_bit, new_bit, lo_bit, hi_bit;
   logic [DATA_WIDTH-1:0] old_word, wr_word, rd_word;

   // Fault evaluation for the operation sitting in S1
   always_comb begin
      addr_ok  = 32'(s1_addr) < CAPACITY;
      vic_ok   = 32'(vic_q) < CAPACITY;
      at_vic   = addr_ok && vic_ok && (s1_addr == vic_q);
      old_word = mem[s1_addr];
      old_bit  = old_word[bit_q];
      new_bit  = s1_wdata[bit_q];
      lo_bit   = (vic_q != '0) ? mem[vic_q - ADDR_WIDTH'(1)][bit_q] : 1'b0;
      hi_bit   = (32'(vic_q) + 32'd1 < CAPACITY) ? mem[vic_q + ADDR_WIDTH'(1)][bit_q] : 1'b0;
      wr_word  = s1_wdata;
      cpl_flip = 1'b0;
      rd_word  = addr_ok ? old_word : '0;
      we       = s1_wr && addr_ok;
      hit      = 1'b0;

      if (we) begin
         case (mode_q)
            M_SA0:  if (at_vic) wr_word[bit_q] = 1'b0;
            M_SA1:  if (at_vic) wr_word[bit_q] = 1'b1;
            M_TUP:  if (at_vic && !old_bit && new_bit) wr_word[bit_q] = 1'b0;
            M_TDN:  if (at_vic && old_bit && !new_bit) wr_word[bit_q] = 1'b1;
            M_CPL:  cpl_flip = vic_ok && (aggr_q != vic_q) && (s1_addr == aggr_q) &&
                               (old_bit != new_bit);
            M_NPSF: if (at_vic && lo_bit && hi_bit) wr_word[bit_q] = old_bit;
            default: ;
         endcase
         hit = (wr_word != s1_wdata) || cpl_flip;
      end else if (!s1_wr && at_vic && (mode_q == M_SA0 || mode_q == M_SA1)) begin
         rd_word[bit_q] = (mode_q == M_SA1);
         hit = (ideal[s1_addr][bit_q] != rd_word[bit_q]);
      end
   end

   // S1 operation capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_wr    <= 1'b0;
         s1_addr  <= '0;
         s1_wdata <= '0;
      end else begin
         s1_wr    <= write_read;
         s1_addr  <= address;
         s1_wdata <= wdata;
      end
   end

   // Fault configuration latch; a commit on the load edge still sees the old values
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q <= M_NONE;
         vic_q  <= '0;
         aggr_q <= '0;
         bit_q  <= '0;
      end else if (cfg_load) begin
         mode_q <= mode_t'(cfg_mode);
         vic_q  <= cfg_victim;
         aggr_q <= cfg_aggr;
         bit_q  <= cfg_bit;
      end
   end

   // Two-stage read return and saturating fault activation counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q       <= '0;
         rdata      <= '0;
         fault_hits <= '0;
      end else begin
         if (!s1_wr) rd_q <= rd_word;
         rdata <= rd_q;
         if (hit && fault_hits != 16'hFFFF) fault_hits <= fault_hits + 16'd1;
      end
   end

   // Array update; contents survive reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (we) begin
            mem[s1_addr]   <= wr_word;
            ideal[s1_addr] <= s1_wdata;
         end
         if (cpl_flip) mem[vic_q][bit_q] <= ~mem[vic_q][bit_q];
      end
   end

endmodule

// File: tb/tb_fault_mem_multi.sv
// Bench for fault_mem_multi: directed scenarios followed by random traffic,
// both checked every cycle against a word-level reference model.
module tb_fault_mem_multi;

   localparam int unsigned DW   = 8;
   localparam int unsigned AW   = 6;
   localparam int unsigned CAP  = 60;
   localparam int unsigned BW   = 3;
   localparam int          PARK = 63;

   logic          clk = 1'b0;
   logic          rst;
   logic          write_read;
   logic [AW-1:0] address;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;
   logic          cfg_load;
   logic [2:0]    cfg_mode;
   logic [AW-1:0] cfg_victim;
   logic [AW-1:0] cfg_aggr;
   logic [BW-1:0] cfg_bit;
   logic [15:0]   fault_hits;

   int checks   = 0;
   int failures = 0;

   fault_mem_multi #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP)) dut (
      .clk(clk), .rst(rst), .write_read(write_read), .address(address),
      .wdata(wdata), .rdata(rdata), .cfg_load(cfg_load), .cfg_mode(cfg_mode),
      .cfg_victim(cfg_victim), .cfg_aggr(cfg_aggr), .cfg_bit(cfg_bit),
      .fault_hits(fault_hits)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [7:0]  mm [64];
   logic [7:0]  ideal [64];
   logic        m_s1_wr;
   int          m_s1_a;
   logic [7:0]  m_s1_d;
   logic [7:0]  m_rd, m_rdata;
   logic [15:0] m_hits;
   int          m_mode, m_vic, m_aggr, m_bit;

   task automatic model_reset();
      m_s1_wr = 1'b0; m_s1_a = 0; m_s1_d = 8'h00;
      m_rd = 8'h00; m_rdata = 8'h00; m_hits = 16'h0000;
      m_mode = 0; m_vic = 0; m_aggr = 0; m_bit = 0;
   endtask

   task automatic bump(input logic h);
      if (h && m_hits != 16'hFFFF) m_hits = m_hits + 16'd1;
   endtask

   task automatic m_write(input int a, input logic [7:0] w);
      logic [7:0] mask, old, d;
      logic       lo, hi, flip;
      if (a >= CAP) return;
      mask = 8'(1) << m_bit;
      old  = mm[a];
      d    = w;
      flip = 1'b0;
      case (m_mode)
         1: if (a == m_vic) d = w & ~mask;
         2: if (a == m_vic) d = w | mask;
         3: if (a == m_vic && (old & mask) == 0 && (w & mask) != 0) d = w & ~mask;
         4: if (a == m_vic && (old & mask) != 0 && (w & mask) == 0) d = w | mask;
         5: if (m_aggr != m_vic && a == m_aggr && m_vic < CAP && ((old ^ w) & mask) != 0) begin
               mm[m_vic] = mm[m_vic] ^ mask;
               flip = 1'b1;
            end
         6: if (a == m_vic) begin
               lo = (m_vic == 0) ? 1'b0 : ((mm[m_vic-1] & mask) != 0);
               hi = (m_vic + 1 >= CAP) ? 1'b0 : ((mm[m_vic+1] & mask) != 0);
               if (lo && hi) d = (w & ~mask) | (old & mask);
            end
         default: ;
      endcase
      mm[a]    = d;
      ideal[a] = w;
      bump((d != w) || flip);
   endtask

   task automatic m_read(input int a, output logic [7:0] v);
      logic [7:0] mask;
      mask = 8'(1) << m_bit;
      if (a >= CAP) begin
         v = 8'h00;
         return;
      end
      v = mm[a];
      if ((m_mode == 1 || m_mode == 2) && a == m_vic) begin
         v = (m_mode == 2) ? (v | mask) : (v & ~mask);
         bump((v & mask) != (ideal[a] & mask));
      end
   endtask

   // Model of one rising edge, using the inputs presented on that edge
   task automatic model_edge();
      logic [7:0] nxt;
      nxt = m_rd;
      if (m_s1_wr) m_write(m_s1_a, m_s1_d);
      else m_read(m_s1_a, m_rd);
      m_rdata = nxt;
      if (cfg_load) begin
         m_mode = int'(cfg_mode); m_vic = int'(cfg_victim);
         m_aggr = int'(cfg_aggr); m_bit = int'(cfg_bit);
      end
      m_s1_wr = write_read; m_s1_a = int'(address); m_s1_d = wdata;
   endtask

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One operation per cycle; outputs compared against the model at the falling edge
   task automatic step(input logic wr, input int a, input logic [7:0] d);
      write_read = wr; address = AW'(a); wdata = d;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      cfg_load = 1'b0;
      check("cyc_rdata", 16'(rdata), 16'(m_rdata));
      check("cyc_hits", fault_hits, m_hits);
   endtask

   task automatic park();
      step(1'b0, PARK, 8'h00);
   endtask

   task automatic load(input int mode, input int vic, input int aggr, input int b);
      cfg_mode = 3'(mode); cfg_victim = AW'(vic); cfg_aggr = AW'(aggr); cfg_bit = BW'(b);
      cfg_load = 1'b1;
      park();
   endtask

   initial begin
      logic [15:0] h0;
      int a, pick, rv, ra;

      rst = 1'b1; write_read = 1'b0; address = '0; wdata = '0;
      cfg_load = 1'b0; cfg_mode = '0; cfg_victim = '0; cfg_aggr = '0; cfg_bit = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_rdata", 16'(rdata), 16'h0000);
      check("reset_hits", fault_hits, 16'h0000);
      rst = 1'b0;

      // Give every in-range word a known value
      for (int i = 0; i < int'(CAP); i++) step(1'b1, i, 8'($urandom));

      // Plain write/read
      step(1'b1, 3, 8'hA5); step(1'b0, 3, 8'h00); park(); park();
      check("mode0_rdata", 16'(rdata), 16'h00A5);
      check("mode0_hits", fault_hits, 16'h0000);

      // Out-of-range write is dropped, read returns zero
      step(1'b1, 62, 8'hFF); step(1'b0, 62, 8'h00); park(); park();
      check("oor_rdata", 16'(rdata), 16'h0000);

      // Stuck-at-1 on victim 5 bit 0
      load(2, 5, 0, 0);
      h0 = m_hits;
      step(1'b1, 5, 8'h00); step(1'b0, 5, 8'h00);
      check("sa1_hits_wr", fault_hits, h0 + 16'd1);
      park();
      check("sa1_hits_rd", fault_hits, h0 + 16'd2);
      park();
      check("sa1_rdata", 16'(rdata), 16'h0001);

      // Transition-up on victim 7 bit 4
      load(3, 7, 0, 4);
      step(1'b1, 7, 8'h00); step(1'b1, 7, 8'hFF); step(1'b0, 7, 8'h00); park(); park();
      check("tup_rdata", 16'(rdata), 16'h00EF);

      // Inversion coupling aggressor 2 -> victim 9 bit 1
      load(0, 0, 0, 0);
      step(1'b1, 2, 8'h00);
      load(5, 9, 2, 1);
      step(1'b1, 9, 8'h00); step(1'b1, 2, 8'h00); step(1'b1, 2, 8'h02);
      step(1'b0, 9, 8'h00); park(); park();
      check("cpl_rdata", 16'(rdata), 16'h0002);
      step(1'b1, 2, 8'h02); step(1'b0, 9, 8'h00); park(); park();
      check("cpl_rewrite", 16'(rdata), 16'h0002);

      // NPSF at victim 0: lower neighbour missing, so no fault
      load(6, 0, 0, 3);
      h0 = m_hits;
      step(1'b1, 1, 8'h08); step(1'b1, 0, 8'h00); step(1'b0, 0, 8'h00); park(); park();
      check("npsf_rdata", 16'(rdata), 16'h0000);
      check("npsf_hits", fault_hits, h0);

      // Reset while a write to address 4 is pending in S1
      load(0, 0, 0, 0);
      step(1'b1, 4, 8'h33);
      write_read = 1'b1; address = AW'(4); wdata = 8'h55;
      @(posedge clk);
      model_edge();
      #2 rst = 1'b1;
      model_reset();
      #1;
      check("rst_rdata", 16'(rdata), 16'h0000);
      check("rst_hits", fault_hits, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 4, 8'h00); park(); park();
      check("rst_keep", 16'(rdata), 16'h0033);

      // Random traffic concentrated around the configured fault sites
      rv = 0; ra = 0;
      for (int n = 0; n < 700; n++) begin
         if ($urandom_range(0, 15) == 0) begin
            rv = $urandom_range(0, CAP);
            ra = ($urandom_range(0, 5) == 0) ? rv : $urandom_range(0, 63);
            cfg_mode = 3'($urandom_range(0, 7)); cfg_victim = AW'(rv);
            cfg_aggr = AW'(ra); cfg_bit = BW'($urandom_range(0, 7));
            cfg_load = 1'b1;
         end
         pick = $urandom_range(0, 4);
         case (pick)
            0: a = $urandom_range(0, 63);
            1: a = (rv + 63) % 64;
            2: a = (rv + 1) % 64;
            3: a = ra;
            default: a = rv;
         endcase
         step(1'($urandom_range(0, 1)), a, 8'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
